// File: rtl/iso_tx_core_pkg.sv
// iso_tx_core_pkg
// Definitions shared by the ISO7816-3 UART receive and transmit cores:
// the frame state encoding, the default start/stop line levels and the
// data-bit ordering helper.
package iso_tx_core_pkg;

  // Frame states. The receive core uses the same START..STOP2 codes.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } txState_t;

  localparam logic DEFAULT_START_BIT = 1'b0;
  localparam logic DEFAULT_STOP_BIT1 = 1'b1;
  localparam logic DEFAULT_STOP_BIT2 = 1'b1;

  // Data bit sent in slot idx: b[idx] for LSB-first, b[7-idx] for MSB-first.
  function automatic logic dataBit(input logic [7:0] b, input logic [2:0] idx,
                                   input logic msb);
    logic [2:0] pos;
    pos = msb ? (3'd7 - idx) : idx;
    return b[pos];
  endfunction

endpackage

// File: rtl/iso_tx_core_counter.sv
// iso_tx_core_counter
// Bit-timing counter: counts 0..maxCount while enabled, then wraps to 0.
// Ports:
//   clk, nReset  clock and asynchronous active-low reset
//   clear        forces the count to zero (wins over enable)
//   enable       advance the count this cycle
//   maxCount     last count value before wrapping
//   count        current count
//   wrap         high in the cycle where an enabled count sits on maxCount
module iso_tx_core_counter #(
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] maxCount,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  assign wrap = enable && (count == maxCount);

  // Count register: cleared, wrapped, advanced or held.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      count <= {WIDTH{1'b0}};
    end else if (clear || wrap) begin
      count <= {WIDTH{1'b0}};
    end else if (enable) begin
      count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/iso_tx_core.sv
// iso_tx_core
// ISO7816-3 character transmitter: start, 8 data bits, parity, stop1 and an
// optional stop2, each bit clocksPerBit cycles long. A one-deep holding
// register allows gap-free back-to-back frames. The line is sensed at the
// end of stop1 to catch the receiver's error signal (NACK).
// Ports:
//   clk, nReset       clock and asynchronous active-low reset
//   dataIn/loadDataIn byte to send and its write strobe (taken when !txFull)
//   clocksPerBit      cycles per etu, sampled at each frame start
//   stopBit2          add a second stop bit
//   oddParity         odd (1) or even (0) parity over data plus parity bit
//   msbFirst          send b7 first when set, b0 first otherwise
//   serialIn          sensed line level, expected already synchronous to clk
//   ackFlags          clears errorSignalFlag
//   serialOut         line drive
//   txFull            holding register occupied
//   run               a frame is in progress
//   endOfTx           pulse in the final cycle of the last stop bit
//   errorSignalFlag   sticky NACK indication
module iso_tx_core
  import iso_tx_core_pkg::*;
#(
  parameter int   CLOCK_PER_BIT_WIDTH = 13,
  parameter logic START_BIT           = DEFAULT_START_BIT,
  parameter logic STOP_BIT1           = DEFAULT_STOP_BIT1,
  parameter logic STOP_BIT2           = DEFAULT_STOP_BIT2
) (
  input  logic                           clk,
  input  logic                           nReset,
  input  logic [7:0]                     dataIn,
  input  logic                           loadDataIn,
  input  logic [CLOCK_PER_BIT_WIDTH-1:0] clocksPerBit,
  input  logic                           stopBit2,
  input  logic                           oddParity,
  input  logic                           msbFirst,
  input  logic                           serialIn,
  input  logic                           ackFlags,
  output logic                           serialOut,
  output logic                           txFull,
  output logic                           run,
  output logic                           endOfTx,
  output logic                           errorSignalFlag
);

  localparam logic [CLOCK_PER_BIT_WIDTH-1:0] CPB_ONE =
    {{(CLOCK_PER_BIT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CLOCK_PER_BIT_WIDTH-1:0] CPB_TWO =
    {{(CLOCK_PER_BIT_WIDTH-2){1'b0}}, 2'b10};

  txState_t                       state;
  txState_t                       nextState;
  logic                           nextSerialOut;
  logic                           loadFrame;
  logic                           frameEnd;
  logic [7:0]                     holdReg;
  logic [7:0]                     shiftReg;
  logic [CLOCK_PER_BIT_WIDTH-1:0] cpbReg;
  logic [CLOCK_PER_BIT_WIDTH-1:0] bitCount;
  logic                           bitWrap;
  logic [2:0]                     bitCounter;
  logic                           parityAcc;
  logic                           currentBit;
  logic                           lastStop;
  logic                           errSet;

  iso_tx_core_counter #(
    .WIDTH(CLOCK_PER_BIT_WIDTH)
  ) bitTimer (
    .clk     (clk),
    .nReset  (nReset),
    .clear   (state == IDLE),
    .enable  (state != IDLE),
    .maxCount(cpbReg - CPB_ONE),
    .count   (bitCount),
    .wrap    (bitWrap)
  );

  assign currentBit = dataBit(shiftReg, bitCounter, msbFirst);
  assign lastStop   = (state == STOP2) || ((state == STOP1) && !stopBit2);
  assign errSet     = (state == STOP1) && bitWrap && (serialIn != STOP_BIT1);

  // Next state and next line level; serialOut is registered so it lines up with state.
  always_comb begin
    nextState     = state;
    nextSerialOut = serialOut;
    loadFrame     = 1'b0;
    frameEnd      = 1'b0;
    case (state)
      IDLE: begin
        nextState = IDLE;
      end
      START: begin
        if (bitWrap) begin
          nextState     = DATA;
          nextSerialOut = dataBit(shiftReg, 3'd0, msbFirst);
        end else begin
          nextState = START;
        end
      end
      DATA: begin
        if (bitWrap) begin
          if (bitCounter == 3'd7) begin
            nextState = PARITY;
            // Accumulator plus the last data bit, which is folded in on this same edge.
            nextSerialOut = parityAcc ^ currentBit;
          end else begin
            nextSerialOut = dataBit(shiftReg, bitCounter + 3'd1, msbFirst);
          end
        end else begin
          nextState = DATA;
        end
      end
      PARITY: begin
        if (bitWrap) begin
          nextState     = STOP1;
          nextSerialOut = STOP_BIT1;
        end else begin
          nextState = PARITY;
        end
      end
      STOP1: begin
        if (bitWrap && stopBit2) begin
          nextState     = STOP2;
          nextSerialOut = STOP_BIT2;
        end else begin
          frameEnd = bitWrap;
        end
      end
      STOP2: begin
        frameEnd = bitWrap;
      end
      default: begin
        nextState     = IDLE;
        nextSerialOut = STOP_BIT1;
      end
    endcase
    // A queued byte starts straight from IDLE or from the last stop bit, with no gap.
    if (frameEnd || (state == IDLE)) begin
      if (txFull) begin
        loadFrame     = 1'b1;
        nextState     = START;
        nextSerialOut = START_BIT;
      end else begin
        nextState     = IDLE;
        nextSerialOut = STOP_BIT1;
      end
    end else begin
      loadFrame = 1'b0;
    end
  end

  // State register and registered control outputs.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state     <= IDLE;
      serialOut <= STOP_BIT1;
      run       <= 1'b0;
      endOfTx   <= 1'b0;
    end else begin
      state     <= nextState;
      serialOut <= nextSerialOut;
      run       <= (nextState != IDLE);
      // One cycle early so the registered pulse lands on the final cycle.
      endOfTx   <= lastStop && (bitCount == (cpbReg - CPB_TWO));
    end
  end

  // Holding register: written only when empty, emptied when a frame starts.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      holdReg <= 8'h00;
      txFull  <= 1'b0;
    end else if (loadFrame) begin
      holdReg <= holdReg;
      txFull  <= 1'b0;
    end else if (loadDataIn && !txFull) begin
      holdReg <= dataIn;
      txFull  <= 1'b1;
    end else begin
      holdReg <= holdReg;
      txFull  <= txFull;
    end
  end

  // Per-frame data path: shift register, latched etu length, data index and parity.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      shiftReg   <= 8'h00;
      cpbReg     <= {CLOCK_PER_BIT_WIDTH{1'b0}};
      bitCounter <= 3'd0;
      parityAcc  <= 1'b0;
    end else if (loadFrame) begin
      shiftReg   <= holdReg;
      cpbReg     <= clocksPerBit;
      bitCounter <= 3'd0;
      parityAcc  <= oddParity;
    end else if ((state == DATA) && bitWrap) begin
      shiftReg   <= shiftReg;
      cpbReg     <= cpbReg;
      bitCounter <= bitCounter + 3'd1;
      parityAcc  <= parityAcc ^ currentBit;
    end else begin
      shiftReg   <= shiftReg;
      cpbReg     <= cpbReg;
      bitCounter <= bitCounter;
      parityAcc  <= parityAcc;
    end
  end

  // Sticky NACK flag; a new detection wins over a simultaneous acknowledge.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      errorSignalFlag <= 1'b0;
    end else if (errSet) begin
      errorSignalFlag <= 1'b1;
    end else if (ackFlags) begin
      errorSignalFlag <= 1'b0;
    end else begin
      errorSignalFlag <= errorSignalFlag;
    end
  end

endmodule

// File: tb/tb_iso_tx_core.sv
// tb_iso_tx_core
// Self-checking bench for iso_tx_core: a frame-level model expands each
// character into its per-cycle line levels, and every output is compared
// against it on every falling clock edge. Directed scenarios add literal
// expectations; a randomized phase follows.
module tb_iso_tx_core;

  logic        clk;
  logic        nReset;
  logic [7:0]  dataIn;
  logic        loadDataIn;
  logic [12:0] clocksPerBit;
  logic        stopBit2;
  logic        oddParity;
  logic        msbFirst;
  logic        serialIn;
  logic        ackFlags;
  logic        serialOut;
  logic        txFull;
  logic        run;
  logic        endOfTx;
  logic        errorSignalFlag;

  int nChecks = 0;
  int nFails  = 0;
  bit checkEn = 1'b0;

  // Model state: outputs expected in the current cycle plus remaining frame levels.
  logic       mLine = 1'b1;
  logic       mRun  = 1'b0;
  logic       mEnd  = 1'b0;
  logic       mFull = 1'b0;
  logic       mErr  = 1'b0;
  logic [7:0] mHold = 8'h00;
  int         mPos  = 0;
  int         mCpb  = 4;
  bit         lineQ[$];

  iso_tx_core dut (
    .clk            (clk),
    .nReset         (nReset),
    .dataIn         (dataIn),
    .loadDataIn     (loadDataIn),
    .clocksPerBit   (clocksPerBit),
    .stopBit2       (stopBit2),
    .oddParity      (oddParity),
    .msbFirst       (msbFirst),
    .serialIn       (serialIn),
    .ackFlags       (ackFlags),
    .serialOut      (serialOut),
    .txFull         (txFull),
    .run            (run),
    .endOfTx        (endOfTx),
    .errorSignalFlag(errorSignalFlag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkBit(input string name, input logic act, input logic exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Expand one character into its line level for every cycle of the frame.
  task automatic buildFrame(input logic [7:0] b);
    logic [11:0] bits;
    int nBits;
    int ones;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = msbFirst ? b[7-i] : b[i];
    ones    = $countones(b);
    bits[9] = oddParity ? ((ones % 2) == 0) : ((ones % 2) == 1);
    bits[10] = 1'b1;
    bits[11] = 1'b1;
    nBits = stopBit2 ? 12 : 11;
    mCpb  = int'(clocksPerBit);
    lineQ.delete();
    for (int k = 0; k < nBits; k++)
      for (int c = 0; c < mCpb; c++) lineQ.push_back(bits[k]);
  endtask

  // Model update, one step per clock, reset asynchronously.
  always @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      mLine = 1'b1; mRun = 1'b0; mEnd = 1'b0; mFull = 1'b0; mErr = 1'b0;
      mHold = 8'h00; mPos = 0;
      lineQ.delete();
    end else begin
      bit frameDone;
      bit startNow;
      bit errHit;
      frameDone = mRun && (lineQ.size() == 0);
      startNow  = mFull && (!mRun || frameDone);
      errHit    = mRun && (mPos == 11 * mCpb - 1) && (serialIn != 1'b1);
      if (errHit) mErr = 1'b1;
      else if (ackFlags) mErr = 1'b0;
      if (startNow) begin
        buildFrame(mHold);
        mLine = lineQ.pop_front();
        mRun  = 1'b1;
        mPos  = 0;
      end else if (mRun && !frameDone) begin
        mLine = lineQ.pop_front();
        mPos++;
      end else begin
        mRun  = 1'b0;
        mLine = 1'b1;
      end
      if (startNow) begin
        mFull = 1'b0;
      end else if (loadDataIn && !mFull) begin
        mFull = 1'b1;
        mHold = dataIn;
      end
      mEnd = mRun && (lineQ.size() == 0);
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkBit("serialOut", serialOut, mLine);
      checkBit("run", run, mRun);
      checkBit("txFull", txFull, mFull);
      checkBit("endOfTx", endOfTx, mEnd);
      checkBit("errorSignalFlag", errorSignalFlag, mErr);
    end
  end

  task automatic loadByte(input logic [7:0] b);
    dataIn     = b;
    loadDataIn = 1'b1;
    @(negedge clk);
    loadDataIn = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((run || txFull) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkBit("idle reached", run || txFull, 1'b0);
  endtask

  task automatic waitRun();
    int n = 0;
    while (!run && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkBit("frame start", run, 1'b1);
  endtask

  task automatic setConfig(input logic [12:0] cpb, input logic s2,
                           input logic odd, input logic msb);
    waitIdle();
    clocksPerBit = cpb;
    stopBit2     = s2;
    oddParity    = odd;
    msbFirst     = msb;
    @(negedge clk);
  endtask

  // Called right after loadByte; cycle 1 is the first cycle of the frame.
  task automatic captureFrame(input int cpb, output logic [11:0] bitsOut,
                              output int eotCycle, output int runFall);
    bitsOut  = 12'h000;
    eotCycle = -1;
    runFall  = -1;
    waitRun();
    for (int c = 1; c <= 60; c++) begin
      if (((c - 1) % cpb == 0) && ((c - 1) / cpb < 12)) bitsOut[(c-1)/cpb] = serialOut;
      if (endOfTx && eotCycle < 0) eotCycle = c;
      if (!run && runFall < 0) runFall = c;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [11:0] bits;
    logic [11:0] bits2;
    int eot;
    int rf;
    int eot1;
    int eot2;

    nReset = 1'b1; dataIn = 8'h00; loadDataIn = 1'b0; clocksPerBit = 13'd4;
    stopBit2 = 1'b0; oddParity = 1'b0; msbFirst = 1'b0; serialIn = 1'b1;
    ackFlags = 1'b0;
    #1 nReset = 1'b0;
    repeat (3) @(negedge clk);
    checkEn = 1'b1;
    checkBit("reset serialOut", serialOut, 1'b1);
    checkBit("reset run", run, 1'b0);
    checkBit("reset txFull", txFull, 1'b0);
    checkBit("reset endOfTx", endOfTx, 1'b0);
    checkBit("reset errorSignalFlag", errorSignalFlag, 1'b0);
    @(posedge clk);
    #2 nReset = 1'b1;
    @(negedge clk);

    // Basic frame, LSB first, even parity.
    loadByte(8'hA5);
    captureFrame(4, bits, eot, rf);
    checkInt("A5 line bits", int'(bits[10:0]), int'(11'b10101001010));
    checkInt("A5 endOfTx cycle", eot, 44);
    checkInt("A5 run fall cycle", rf, 45);

    // MSB first, odd parity.
    setConfig(13'd4, 1'b0, 1'b1, 1'b1);
    loadByte(8'h03);
    captureFrame(4, bits, eot, rf);
    checkInt("03 msb/odd line bits", int'(bits[10:0]), int'(11'b11110000000));
    checkInt("03 endOfTx cycle", eot, 44);

    // Back-to-back with two stop bits plus an ignored overflow write.
    setConfig(13'd4, 1'b1, 1'b0, 1'b0);
    loadByte(8'h11);
    waitRun();
    eot1 = -1; eot2 = -1; bits2 = 12'h000;
    for (int c = 1; c <= 100; c++) begin
      if (endOfTx && eot1 < 0) eot1 = c;
      else if (endOfTx && eot2 < 0) eot2 = c;
      if (c == 20) begin dataIn = 8'h22; loadDataIn = 1'b1; end
      if (c == 21) loadDataIn = 1'b0;
      if (c == 30) begin dataIn = 8'h33; loadDataIn = 1'b1; end
      if (c == 31) loadDataIn = 1'b0;
      if (c == 40) checkBit("b2b txFull mid-frame", txFull, 1'b1);
      if (c == 48) checkBit("b2b txFull at frame end", txFull, 1'b1);
      if (c == 49) begin
        checkBit("b2b second start bit", serialOut, 1'b0);
        checkBit("b2b run stays high", run, 1'b1);
      end
      if (c == 50) checkBit("b2b txFull after start", txFull, 1'b0);
      if ((c >= 50) && ((c - 50) % 4 == 0) && ((c - 50) / 4 < 12)) bits2[(c-50)/4] = serialOut;
      @(negedge clk);
    end
    checkInt("b2b first endOfTx", eot1, 48);
    checkInt("b2b second endOfTx", eot2, 96);
    checkInt("b2b 22 line bits", int'(bits2), int'(12'b110001000100));

    // Error signal: clean frame first, then a NACK across the end of stop1.
    setConfig(13'd4, 1'b0, 1'b0, 1'b0);
    loadByte(8'h5A);
    captureFrame(4, bits, eot, rf);
    checkBit("no NACK flag", errorSignalFlag, 1'b0);
    loadByte(8'hC3);
    waitRun();
    for (int c = 1; c <= 50; c++) begin
      if (c == 43) serialIn = 1'b0;
      if (c == 48) serialIn = 1'b1;
      if (c == 44) checkBit("flag before stop1 end", errorSignalFlag, 1'b0);
      if (c == 45) checkBit("flag after stop1", errorSignalFlag, 1'b1);
      @(negedge clk);
    end
    loadByte(8'h0F);
    captureFrame(4, bits, eot, rf);
    checkBit("flag sticky across frame", errorSignalFlag, 1'b1);
    ackFlags = 1'b1;
    @(negedge clk);
    ackFlags = 1'b0;
    checkBit("flag cleared by ack", errorSignalFlag, 1'b0);

    // Asynchronous reset during data bit 3 with a byte queued.
    loadByte(8'h96);
    waitRun();
    for (int c = 1; c <= 17; c++) begin
      if (c == 5) begin dataIn = 8'h77; loadDataIn = 1'b1; end
      if (c == 6) loadDataIn = 1'b0;
      @(negedge clk);
    end
    checkBit("pre-reset txFull", txFull, 1'b1);
    #2 nReset = 1'b0;
    #1;
    checkBit("async reset serialOut", serialOut, 1'b1);
    checkBit("async reset run", run, 1'b0);
    checkBit("async reset txFull", txFull, 1'b0);
    @(posedge clk);
    #2 nReset = 1'b1;
    @(negedge clk);
    loadByte(8'h3C);
    captureFrame(4, bits, eot, rf);
    checkInt("post-reset 3C line bits", int'(bits[10:0]), int'(11'b10001111000));
    checkInt("post-reset endOfTx cycle", eot, 44);

    // Randomized traffic, configuration changed only while idle.
    for (int r = 0; r < 20; r++) begin
      int nCyc;
      setConfig(13'($urandom_range(4, 10)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      nCyc = int'($urandom_range(100, 400));
      for (int c = 0; c < nCyc; c++) begin
        loadDataIn = ($urandom_range(0, 5) == 0);
        dataIn     = 8'($urandom);
        ackFlags   = ($urandom_range(0, 15) == 0);
        serialIn   = ($urandom_range(0, 7) != 0);
        @(negedge clk);
      end
      loadDataIn = 1'b0;
      ackFlags   = 1'b0;
      serialIn   = 1'b1;
    end
    waitIdle();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/iso_tx_core.md
Name: iso_tx_core

Overview:
- Character transmitter for the ISO7816-3 UART link; it is the send-side counterpart of the existing receive core and shares its conventions (start/stop polarity, parity sense, bit order, clocksPerBit timing).
- Serializes one byte as a frame: start, 8 data bits, parity, stop1, then an optional stop2.
- A one-deep holding register allows back-to-back characters.
- Senses the line during stop1 to detect the ISO7816 error signal (NACK) from the receiver. Retransmission is decided by the upper layer, not by this block.

Parameters:
- CLOCK_PER_BIT_WIDTH, 13, width of clocksPerBit and of the internal bit-timing counter.
- START_BIT, 1'b0, line level of the start bit.
- STOP_BIT1, 1'b1, line level of stop bit 1. Also the idle level.
- STOP_BIT2, 1'b1, line level of stop bit 2.

Ports:
- clk  input  1  system clock; every register is clocked on the rising edge.
- nReset  input  1  asynchronous, active-low reset.
- dataIn  input  8  byte to send.
- loadDataIn  input  1  one-cycle write strobe; captured only when txFull=0.
- clocksPerBit  input  CLOCK_PER_BIT_WIDTH  cycles per elementary time unit (etu), minimum 4. Sampled at each frame start.
- stopBit2  input  1  0: one stop bit, 1: two stop bits.
- oddParity  input  1  1: data plus parity together hold an odd number of 1s.
- msbFirst  input  1  1: data order is b7..b0; 0: data order is b0..b7.
- serialIn  input  1  sensed line level, used for error-signal detection.
- ackFlags  input  1  clears errorSignalFlag.
- serialOut  output  1  line drive.
- txFull  output  1  holding register occupied.
- run  output  1  a frame is in progress.
- endOfTx  output  1  one-cycle pulse in the last cycle of the last stop bit.
- errorSignalFlag  output  1  receiver NACK detected on the last frame.

Behaviour:
- Reset values: state IDLE, serialOut=STOP_BIT1, txFull=0, run=0, endOfTx=0, errorSignalFlag=0. The bit counter, data counter and holding register are cleared. Reset mid-frame aborts immediately and the line returns to the idle level.
- Write rule:
  - loadDataIn with txFull=0 latches dataIn and sets txFull on the next cycle.
  - loadDataIn with txFull=1 is ignored and does not corrupt the held byte.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2. Each bit lasts exactly clocksPerBit cycles, timed by an internal counter that runs 0..clocksPerBit-1 and then wraps.
- IDLE → START:
  - Taken when txFull=1.
  - The held byte moves to the shift register, txFull clears, run=1 and the parity accumulator loads oddParity.
  - serialOut=START_BIT from the cycle after the transition decision.
  - Latency: loadDataIn in IDLE puts the start bit on serialOut 2 cycles later.
- START → DATA after clocksPerBit cycles.
- DATA:
  - Sends 8 bits; the index is bitCounter or 7-bitCounter when msbFirst=1.
  - Each sent bit is XORed into the parity accumulator.
  - bitCounter wraps 7→0, and the state moves to PARITY.
- PARITY:
  - serialOut = accumulator value, so the count of 1s in data plus parity is odd when oddParity=1 and even otherwise.
  - Moves to STOP1.
- STOP1:
  - serialOut=STOP_BIT1.
  - In the cycle where counter == clocksPerBit-1 (≈11 etu), serialIn != STOP_BIT1 sets errorSignalFlag.
  - Moves to STOP2 if stopBit2=1; otherwise this is the last stop bit.
- STOP2: serialOut=STOP_BIT2.
- Frame end:
  - endOfTx is high during the final cycle of the last stop bit.
  - Next state is START directly if txFull=1 (gap-free back-to-back frames), otherwise IDLE with run=0.
- Frame length: (11+stopBit2)*clocksPerBit cycles.
- errorSignalFlag is sticky until ackFlags. If set and ack happen in the same cycle, set wins.
- Writes during a frame are accepted into the holding register, so the next byte can be queued while the current frame is sent.
- A change of clocksPerBit, stopBit2, oddParity or msbFirst mid-frame is undefined; the upper layer changes them only while run=0.

Decomposition:
- Shared package: the state encodings (START, DATA, PARITY, STOP1, STOP2 codes) and the START_BIT/STOP_BIT defaults, used by both the receive and transmit cores.
- Natural sub-module: the existing Counter block as the bit-timing counter, same connection style as the receive core. Everything else stays inline.

Test Plan:
- Basic frame, clocksPerBit=4, stopBit2=0, oddParity=0, msbFirst=0, load 8'hA5:
  - serialOut holds, 4 cycles each: 0, 1,0,1,0,0,1,0,1, parity 0, stop 1.
  - endOfTx pulses once at cycle 44 of the frame; run falls the next cycle.
- Parity and order, oddParity=1, msbFirst=1, byte 8'h03:
  - Data bits go out 0,0,0,0,0,0,1,1.
  - Parity bit = 1.
- Back-to-back, stopBit2=1, load 8'h11, then load 8'h22 mid-frame:
  - txFull=1 until the first frame ends.
  - The second start bit begins the cycle after endOfTx; no idle gap.
  - Frame length is 48 cycles each.
- Overflow: a third load while txFull=1 is ignored; 8'h22 is still transmitted unchanged.
- Error signal: drive serialIn=0 from 10.5 etu to 12 etu:
  - errorSignalFlag=1 after STOP1.
  - It stays set across the next frame and clears on ackFlags.
  - With serialIn held high the flag stays 0.
- Reset in DATA (nReset low at bit 3):
  - serialOut=1, run=0, txFull=0 immediately, asynchronously.
  - After release, a new load sends a clean frame.
